// File: rtl/plic_irq_seq.sv
// Hart-side PLIC claim/complete sequencer: reads the claim register when the PLIC
// raises irq, hands the id to the core, and writes it back once the handler is done.
module plic_irq_seq #(
  parameter logic [2:0] CLAIM_ADDR = 3'd6,
  parameter int         RD_LAT     = 1,
  parameter int         COOLDOWN   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        plic_irq,
  input  logic [31:0] plic_rdata,
  output logic        plic_load,
  output logic        plic_wr_H_rd_L,
  output logic [2:0]  plic_addr,
  output logic [31:0] plic_wdata,
  input  logic        cpu_irq_en,
  output logic        cpu_irq_req,
  output logic [3:0]  cpu_irq_id,
  input  logic        cpu_irq_ack,
  input  logic        cpu_irq_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, CLAIM, RDWAIT, DELIVER, SERVICE, COMPLETE, COOL
  } state_t;

  localparam logic [2:0] RD_LAST   = 3'(RD_LAT - 1);
  localparam logic [2:0] COOL_LAST = 3'(COOLDOWN - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       rd_ready;
  logic       rdata_unused;

  // With zero read latency the claim data is already valid during the strobe cycle.
  always_comb begin
    rd_ready = 1'b0;
    if (state == CLAIM) rd_ready = (RD_LAT == 0);
    else                rd_ready = (cnt == RD_LAST);
  end

  assign rdata_unused = ^plic_rdata[31:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 3'd0;
      plic_load      <= 1'b0;
      plic_wr_H_rd_L <= 1'b0;
      plic_addr      <= 3'd0;
      plic_wdata     <= 32'd0;
      cpu_irq_req    <= 1'b0;
      cpu_irq_id     <= 4'd0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (plic_irq && cpu_irq_en) begin
            state          <= CLAIM;
            plic_load      <= 1'b1;
            plic_wr_H_rd_L <= 1'b0;
            plic_addr      <= CLAIM_ADDR;
            cpu_irq_id     <= 4'd0;
            busy           <= 1'b1;
            cnt            <= 3'd0;
          end
        end
        CLAIM, RDWAIT: begin
          plic_load <= 1'b0;
          plic_addr <= 3'd0;
          if (rd_ready) begin
            cpu_irq_id <= plic_rdata[3:0];
            cnt        <= 3'd0;
            // A zero id means the PLIC had nothing for us; skip delivery and completion.
            if (plic_rdata[3:0] == 4'd0) begin
              state <= COOL;
            end else begin
              state       <= DELIVER;
              cpu_irq_req <= 1'b1;
            end
          end else begin
            state <= RDWAIT;
            cnt   <= (state == CLAIM) ? 3'd0 : cnt + 3'd1;
          end
        end
        DELIVER: begin
          if (cpu_irq_ack) begin
            cpu_irq_req <= 1'b0;
            if (cpu_irq_done) begin
              state          <= COMPLETE;
              plic_load      <= 1'b1;
              plic_wr_H_rd_L <= 1'b1;
              plic_addr      <= CLAIM_ADDR;
              plic_wdata     <= {28'd0, cpu_irq_id};
            end else begin
              state <= SERVICE;
            end
          end
        end
        SERVICE: begin
          if (cpu_irq_done) begin
            state          <= COMPLETE;
            plic_load      <= 1'b1;
            plic_wr_H_rd_L <= 1'b1;
            plic_addr      <= CLAIM_ADDR;
            plic_wdata     <= {28'd0, cpu_irq_id};
          end
        end
        COMPLETE: begin
          state          <= COOL;
          cnt            <= 3'd0;
          plic_load      <= 1'b0;
          plic_wr_H_rd_L <= 1'b0;
          plic_addr      <= 3'd0;
          plic_wdata     <= 32'd0;
        end
        COOL: begin
          if (cnt == COOL_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plic_irq_seq.sv
// Directed bench for plic_irq_seq with default parameters (CLAIM_ADDR=6, RD_LAT=1, COOLDOWN=2).
module tb_plic_irq_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        plic_irq;
  logic [31:0] plic_rdata;
  logic        plic_load;
  logic        plic_wr_H_rd_L;
  logic [2:0]  plic_addr;
  logic [31:0] plic_wdata;
  logic        cpu_irq_en;
  logic        cpu_irq_req;
  logic [3:0]  cpu_irq_id;
  logic        cpu_irq_ack;
  logic        cpu_irq_done;
  logic        busy;

  plic_irq_seq dut (
    .clk            (clk),
    .rst            (rst),
    .plic_irq       (plic_irq),
    .plic_rdata     (plic_rdata),
    .plic_load      (plic_load),
    .plic_wr_H_rd_L (plic_wr_H_rd_L),
    .plic_addr      (plic_addr),
    .plic_wdata     (plic_wdata),
    .cpu_irq_en     (cpu_irq_en),
    .cpu_irq_req    (cpu_irq_req),
    .cpu_irq_id     (cpu_irq_id),
    .cpu_irq_ack    (cpu_irq_ack),
    .cpu_irq_done   (cpu_irq_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] BUS_IDLE  = 5'b00000;
  localparam logic [4:0] BUS_READ  = 5'b10110;
  localparam logic [4:0] BUS_WRITE = 5'b11110;

  logic [4:0] bus;
  assign bus = {plic_load, plic_wr_H_rd_L, plic_addr};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_count = 0;
  int wr_count = 0;
  int b2b = 0;
  int bad_addr = 0;
  int last_rd_cyc = 0;
  int last_wr_cyc = 0;
  logic prev_load = 1'b0;

  // Bus monitor: counts every strobe and flags back-to-back or misaddressed accesses.
  always @(negedge clk) begin
    cyc++;
    if (plic_load) begin
      if (prev_load) b2b++;
      if (plic_addr != 3'd6) bad_addr++;
      if (plic_wr_H_rd_L) begin
        wr_count++;
        last_wr_cyc = cyc;
      end else begin
        rd_count++;
        last_rd_cyc = cyc;
      end
    end
    prev_load = plic_load;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic irq, input logic en, input logic ack, input logic done,
                               input logic [31:0] rdata);
    plic_irq     = irq;
    cpu_irq_en   = en;
    cpu_irq_ack  = ack;
    cpu_irq_done = done;
    plic_rdata   = rdata;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_bus"}, 32'(bus), 32'(BUS_IDLE));
    checkOutput({tag, "_wdata"}, plic_wdata, 32'd0);
    checkOutput({tag, "_req"}, 32'(cpu_irq_req), 32'd0);
    checkOutput({tag, "_id"}, 32'(cpu_irq_id), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  int r0, w0, wc, gap;

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(3);
    checkAllZero("reset");
    rst = 1'b0;
    step(1);

    // T1: basic claim, ack, done, complete
    r0 = rd_count; w0 = wr_count;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF5);
    step(1);
    checkOutput("t1_read_strobe", 32'(bus), 32'(BUS_READ));
    checkOutput("t1_busy_claim", 32'(busy), 32'd1);
    step(1);
    checkOutput("t1_bus_rdwait", 32'(bus), 32'(BUS_IDLE));
    checkOutput("t1_no_req_rdwait", 32'(cpu_irq_req), 32'd0);
    step(1);
    checkOutput("t1_req", 32'(cpu_irq_req), 32'd1);
    checkOutput("t1_id", 32'(cpu_irq_id), 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd5);
    step(1);
    checkOutput("t1_req_after_ack", 32'(cpu_irq_req), 32'd0);
    checkOutput("t1_busy_service", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd5);
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd5);
    step(1);
    checkOutput("t1_repeat_ack_req", 32'(cpu_irq_req), 32'd0);
    checkOutput("t1_repeat_ack_bus", 32'(bus), 32'(BUS_IDLE));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'd5);
    step(1);
    checkOutput("t1_write_strobe", 32'(bus), 32'(BUS_WRITE));
    checkOutput("t1_wdata", plic_wdata, 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1);
    checkOutput("t1_bus_cool", 32'(bus), 32'(BUS_IDLE));
    checkOutput("t1_wdata_cool", plic_wdata, 32'd0);
    checkOutput("t1_id_hold", 32'(cpu_irq_id), 32'd5);
    checkOutput("t1_busy_cool", 32'(busy), 32'd1);
    step(1);
    checkOutput("t1_busy_cool2", 32'(busy), 32'd1);
    step(1);
    checkOutput("t1_idle", 32'(busy), 32'd0);
    checkOutput("t1_reads", 32'(rd_count - r0), 32'd1);
    checkOutput("t1_writes", 32'(wr_count - w0), 32'd1);

    // T2: spurious claim
    r0 = rd_count; w0 = wr_count;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'hABC0_0000);
    step(1);
    checkOutput("t2_read_strobe", 32'(bus), 32'(BUS_READ));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'hABC0_0000);
    step(2);
    checkOutput("t2_no_req", 32'(cpu_irq_req), 32'd0);
    checkOutput("t2_busy_cool", 32'(busy), 32'd1);
    step(2);
    checkOutput("t2_idle", 32'(busy), 32'd0);
    checkOutput("t2_reads", 32'(rd_count - r0), 32'd1);
    checkOutput("t2_writes", 32'(wr_count - w0), 32'd0);

    // T3 + T4: enable gating, then ack and done together
    r0 = rd_count; w0 = wr_count;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd4);
    step(10);
    checkOutput("t3_no_load_disabled", 32'(rd_count - r0), 32'd0);
    checkOutput("t3_idle_disabled", 32'(busy), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd4);
    step(1);
    checkOutput("t3_claim_after_en", 32'(bus), 32'(BUS_READ));
    step(2);
    checkOutput("t4_req", 32'(cpu_irq_req), 32'd1);
    checkOutput("t4_id", 32'(cpu_irq_id), 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'd4);
    step(1);
    checkOutput("t4_write_strobe", 32'(bus), 32'(BUS_WRITE));
    checkOutput("t4_wdata", plic_wdata, 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(3);
    checkOutput("t4_idle", 32'(busy), 32'd0);
    checkOutput("t4_writes", 32'(wr_count - w0), 32'd1);

    // T5: reset while in SERVICE
    w0 = wr_count;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd9);
    step(3);
    checkOutput("t5_id", 32'(cpu_irq_id), 32'd9);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd9);
    step(1);
    checkOutput("t5_busy_service", 32'(busy), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd9);
    step(1);
    checkAllZero("t5_reset");
    rst = 1'b0;
    step(1);
    checkOutput("t5_reclaim", 32'(bus), 32'(BUS_READ));
    checkOutput("t5_no_write", 32'(wr_count - w0), 32'd0);
    step(2);
    checkOutput("t5_req2", 32'(cpu_irq_req), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'd9);
    step(1);
    checkOutput("t5_wdata", plic_wdata, 32'd9);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(3);
    checkOutput("t5_idle", 32'(busy), 32'd0);

    // T6: irq held high across a complete
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd3);
    step(3);
    checkOutput("t6_id1", 32'(cpu_irq_id), 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'd3);
    step(1);
    checkOutput("t6_wdata1", plic_wdata, 32'd3);
    wc = last_wr_cyc;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd7);
    step(3);
    checkOutput("t6_quiet_cool", 32'(bus), 32'(BUS_IDLE));
    step(1);
    checkOutput("t6_read2", 32'(bus), 32'(BUS_READ));
    gap = last_rd_cyc - wc;
    checkOutput("t6_gap_ge_3", 32'(gap >= 3), 32'd1);
    step(2);
    checkOutput("t6_id2", 32'(cpu_irq_id), 32'd7);
    checkOutput("t6_req2", 32'(cpu_irq_req), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'd7);
    step(1);
    checkOutput("t6_wdata2", plic_wdata, 32'd7);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(3);
    checkOutput("t6_idle", 32'(busy), 32'd0);

    checkOutput("no_back_to_back_load", 32'(b2b), 32'd0);
    checkOutput("access_addr_6", 32'(bad_addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
